audioqsys_blink_pio: RTL and testbench
======================================

Name: audioqsys_blink_pio

Overview:
- Parametrised Avalon-MM output PIO that drives board LEDs. Successor to the fixed 18-bit LED output port.
- Adds configurable width, atomic set/clear registers, and a per-bit hardware blink mode driven by a programmable half-period counter.
- Sits on the Qsys/Avalon bus as a memory-mapped slave. out_port connects directly to the red/green LED pins.

Parameters:
- DATA_WIDTH, 18, number of output bits (1..32).
- RESET_VALUE, 0, DATA register and out_port value after reset.
- CNT_WIDTH, 24, width of the HALF_PERIOD register and blink counter (1..32).
- DEFAULT_HALF_PERIOD, 12500000, HALF_PERIOD reset value in clk cycles (0.25 s half-period at 50 MHz). Must fit in CNT_WIDTH.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  3  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  read data; combinational from address; unused upper bits are 0.
- out_port  output  DATA_WIDTH  registered LED drive.

Behaviour:
- Write strobe: we = chipselect & ~write_n. There is no read side effect and no wait states; read latency is 0 (combinational mux).
- Register map:
  - 0 DATA (RW): writedata[DATA_WIDTH-1:0].
  - 1 BLINK_EN (RW): per-bit blink enable.
  - 2 HALF_PERIOD (RW): writedata[CNT_WIDTH-1:0].
  - 3 STATUS (RO): bit0 = phase, bit1 = blink_running (HALF_PERIOD != 0); other bits 0.
  - 4 OUTSET (WO): DATA <= DATA | wd.
  - 5 OUTCLEAR (WO): DATA <= DATA & ~wd.
  - Reads of 4 and 5 return the current DATA. Addresses 6-7 read 0, and writes to them are ignored.
- Reset values:
  - DATA = RESET_VALUE.
  - BLINK_EN = 0.
  - HALF_PERIOD = DEFAULT_HALF_PERIOD.
  - cnt = 0, phase = 0.
  - out_port = RESET_VALUE.
  - readdata follows the reset register values.
- Blink counter, when HALF_PERIOD != 0:
  - If cnt == HALF_PERIOD-1: cnt <= 0 and phase toggles.
  - Otherwise: cnt <= cnt+1.
  - The phase period is 2*HALF_PERIOD clk cycles.
- HALF_PERIOD == 0: cnt and phase are held at 0, so blinking bits stay dark.
- Write to HALF_PERIOD: cnt <= 0 and phase <= 0 in the same edge. The write has priority over a coincident wrap/toggle.
- HALF_PERIOD shrunk below the current cnt cannot occur, because a write always clears cnt.
- Output logic, registered: out_port[i] <= BLINK_EN[i] ? (DATA[i] & phase) : DATA[i].
  - Uses pre-edge register values, so out_port reflects a bus write 2 clk edges after the write edge (register edge + output edge).
  - A phase toggle appears on out_port one edge after the toggle.
- Writes to BLINK_EN do not disturb cnt or phase.
- Width rules:
  - Register write bits above DATA_WIDTH or CNT_WIDTH are discarded.
  - Reads zero-extend to 32 bits.
- Asserting reset at any time (including mid-count or in the same cycle as a write) forces all reset values immediately. The write is lost.

Test Plan:
- Reset: hold reset with RESET_VALUE=18'h00A5A -> out_port=18'h00A5A, read addr0=32'h00000A5A, addr2=12500000, addr3=32'h2. Writing 32'hFFFFFFFF to addr0 while reset is high -> DATA unchanged.
- Set/clear: write addr0=18'h000F0, addr4=18'h00003, addr5=18'h00030 -> read addr0=18'h000C3, and out_port=18'h000C3 two edges after the last write.
- Blink: HALF_PERIOD=4, DATA=18'h3, BLINK_EN=18'h1 -> out_port bit0 is 0 for 4 cycles then 1 for 4 cycles (repeating); bit1 is constantly 1; STATUS bit0 tracks phase.
- Stop: write HALF_PERIOD=0 mid-high-phase -> phase=0 next edge, bit0 goes low one edge later and stays low, STATUS=32'h0.
- Collision: write HALF_PERIOD=8 on the exact cycle cnt==3 with HALF_PERIOD=4 -> no toggle, cnt=0, phase=0, and the next toggle occurs 8 cycles later.
- Width/unmapped: DATA_WIDTH=8, write addr0=32'hFFFF_FF3C -> read 32'h0000003C; write addr6 -> no register change, read addr6/7=0.

Source files
------------

// File: rtl/audioqsys_blink_pio.sv
// Avalon-MM output PIO for board LEDs: DATA register with atomic set/clear,
// per-bit blink enable, and a programmable half-period blink generator.
// readdata is a zero-latency combinational mux; out_port is registered.
module audioqsys_blink_pio #(
    parameter int                    DATA_WIDTH          = 18,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE         = '0,
    parameter int                    CNT_WIDTH           = 24,
    parameter logic [CNT_WIDTH-1:0]  DEFAULT_HALF_PERIOD = CNT_WIDTH'(12500000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        REG_DATA        = 3'd0,
        REG_BLINK_EN    = 3'd1,
        REG_HALF_PERIOD = 3'd2,
        REG_STATUS      = 3'd3,
        REG_OUTSET      = 3'd4,
        REG_OUTCLEAR    = 3'd5
    } reg_addr_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                  we;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] blink_en_q, blink_en_d;
    logic [CNT_WIDTH-1:0]  half_q, half_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  blink_running;

    assign we            = chipselect & ~write_n;
    assign wd_data       = writedata[DATA_WIDTH-1:0];
    assign blink_running = (half_q != '0);
    assign out_port      = out_q;

    // Register-file next state: plain write, atomic set/clear, unmapped writes ignored.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        data_d     = data_q;
        blink_en_d = blink_en_q;
        half_d     = half_q;
        if (we) begin
            case (address)
                REG_DATA:        data_d     = wd_data;
                REG_BLINK_EN:    blink_en_d = wd_data;
                REG_HALF_PERIOD: half_d     = writedata[CNT_WIDTH-1:0];
                REG_OUTSET:      data_d     = data_q | wd_data;
                REG_OUTCLEAR:    data_d     = data_q & ~wd_data;
                default:         ;
            endcase
        end
    end

    // Blink generator: a HALF_PERIOD write restarts the count and beats a coincident wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (we && (address == REG_HALF_PERIOD)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (!blink_running) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == (half_q - CNT_ONE)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    // LED drive from pre-edge state: blinking bits are gated by the current phase.
    always_comb begin
        out_d = (data_q & ~blink_en_q) | (data_q & blink_en_q & {DATA_WIDTH{phase_q}});
    end

    // All state registers; reset wins over any coincident bus write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            half_q     <= DEFAULT_HALF_PERIOD;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            out_q      <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
        end
    end

    // Zero-latency read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA, REG_OUTSET, REG_OUTCLEAR: readdata[DATA_WIDTH-1:0] = data_q;
            REG_BLINK_EN:    readdata[DATA_WIDTH-1:0] = blink_en_q;
            REG_HALF_PERIOD: readdata[CNT_WIDTH-1:0]  = half_q;
            REG_STATUS:      readdata[1:0]            = {blink_running, phase_q};
            default:         ;
        endcase
    end

endmodule

// File: tb/tb_audioqsys_blink_pio.sv
// Scoreboard bench for audioqsys_blink_pio: stimulus pushes expected
// readdata/out_port values, a negedge monitor pops and compares them.
module tb_audioqsys_blink_pio;

    localparam int DW = 18;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    audioqsys_blink_pio #(
        .DATA_WIDTH         (DW),
        .RESET_VALUE        (18'h00A5A),
        .CNT_WIDTH          (CW),
        .DEFAULT_HALF_PERIOD(24'd12500000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        bit            chk_rd;
        logic [31:0]   exp_rd;
        bit            chk_port;
        logic [DW-1:0] exp_port;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_req = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // One bus write; the register edge is the first posedge after the call.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Queue an expectation for the state visible during the current cycle.
    task automatic expect_cycle(input string name, input bit chk_rd, input logic [2:0] a,
                                input logic [31:0] erd, input bit chk_port,
                                input logic [DW-1:0] ep);
        exp_t e;
        e.name     = name;
        e.chk_rd   = chk_rd;
        e.exp_rd   = erd;
        e.chk_port = chk_port;
        e.exp_port = ep;
        address    = a;
        sb.push_back(e);
        mon_req    = 1'b1;
        @(posedge clk);
        #1;
        mon_req    = 1'b0;
    endtask

    // Monitor: compare DUT outputs on the falling edge whenever an expectation is presented.
    always @(negedge clk) begin
        if (mon_req) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: monitor strobe with empty scoreboard");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk_rd) begin
                    n_tests++;
                    if (readdata !== mon_e.exp_rd) begin
                        n_fail++;
                        $display("FAIL %s readdata: got %h want %h", mon_e.name, readdata, mon_e.exp_rd);
                    end
                end
                if (mon_e.chk_port) begin
                    n_tests++;
                    if (out_port !== mon_e.exp_port) begin
                        n_fail++;
                        $display("FAIL %s out_port: got %h want %h", mon_e.name, out_port, mon_e.exp_port);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ep;
        logic [31:0]   es;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Write while reset is high must be lost.
        address    = 3'd0;
        writedata  = 32'hFFFF_FFFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        expect_cycle("rst_data",   1, 3'd0, 32'h0000_0A5A, 1, 18'h00A5A);
        expect_cycle("rst_blink",  1, 3'd1, 32'h0,         0, '0);
        expect_cycle("rst_half",   1, 3'd2, 32'd12500000,  0, '0);
        expect_cycle("rst_status", 1, 3'd3, 32'h2,         1, 18'h00A5A);
        reset = 1'b0;

        // Set / clear: F0 | 03 = F3, & ~30 = C3.
        bus_write(3'd0, 32'h0000_00F0);
        bus_write(3'd4, 32'h0000_0003);
        bus_write(3'd5, 32'h0000_0030);
        expect_cycle("sc_data", 1, 3'd0, 32'h0000_00C3, 1, 18'h000F3);
        expect_cycle("sc_rd4",  1, 3'd4, 32'h0000_00C3, 1, 18'h000C3);
        expect_cycle("sc_rd5",  1, 3'd5, 32'h0000_00C3, 1, 18'h000C3);

        // Blink: HALF_PERIOD=4, DATA=3, BLINK_EN=1. k = edges since the HALF_PERIOD write.
        bus_write(3'd0, 32'h3);
        bus_write(3'd1, 32'h1);
        bus_write(3'd2, 32'd4);
        for (int k = 0; k < 14; k++) begin
            es = 32'h2 | 32'((k / 4) % 2);
            ep = (k == 0) ? 18'h2 : (18'h2 | 18'((k - 1) / 4 % 2));
            expect_cycle("blink", 1, 3'd3, es, 1, ep);
        end

        // Stop mid high phase: phase clears at once, LED follows one edge later.
        bus_write(3'd2, 32'd0);
        expect_cycle("stop_phase", 1, 3'd3, 32'h0, 1, 18'h3);
        for (int k = 0; k < 4; k++) begin
            expect_cycle("stop_dark", 1, 3'd3, 32'h0, 1, 18'h2);
        end

        // Collision: HALF_PERIOD=8 written on the cycle where cnt==3 with HALF_PERIOD=4.
        bus_write(3'd2, 32'd4);
        for (int j = 0; j < 3; j++) begin
            expect_cycle("col_pre", 1, 3'd3, 32'h2, 1, 18'h2);
        end
        bus_write(3'd2, 32'd8);
        for (int j = 0; j < 9; j++) begin
            es = (j == 8) ? 32'h3 : 32'h2;
            expect_cycle("col_after", 1, 3'd3, es, 1, 18'h2);
        end
        expect_cycle("col_half", 1, 3'd2, 32'd8, 0, '0);

        // Asynchronous reset in the middle of counting.
        reset = 1'b1;
        expect_cycle("mid_rst_data",   1, 3'd0, 32'h0000_0A5A, 1, 18'h00A5A);
        expect_cycle("mid_rst_status", 1, 3'd3, 32'h2,         1, 18'h00A5A);
        reset = 1'b0;

        // Width truncation and unmapped addresses.
        bus_write(3'd0, 32'hFFFF_FF3C);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'hFFFF_FFFF);
        expect_cycle("w_data",  1, 3'd0, 32'h0003_FF3C, 1, 18'h3FF3C);
        expect_cycle("w_rd6",   1, 3'd6, 32'h0,         0, '0);
        expect_cycle("w_rd7",   1, 3'd7, 32'h0,         0, '0);
        expect_cycle("w_blink", 1, 3'd1, 32'h0,         0, '0);
        expect_cycle("w_half",  1, 3'd2, 32'd12500000,  0, '0);
        bus_write(3'd1, 32'hFFFF_FFFF);
        expect_cycle("w_blink_all", 1, 3'd1, 32'h0003_FFFF, 0, '0);
        bus_write(3'd2, 32'hFFFF_FFFF);
        expect_cycle("w_half_max", 1, 3'd2, 32'h00FF_FFFF, 1, 18'h0);
        expect_cycle("w_status",   1, 3'd3, 32'h2,         0, '0);

        repeat (2) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
